// File: rtl/lynx_tape_player.sv
// Cassette playback source: a host fills a 9-bit FIFO and the player plays out a leader tone,
// then the bytes MSB-first as square-wave cycles, then a trailing low gap.
module lynx_tape_player #(
   parameter int FIFO_AW  = 4,
   parameter int H0       = 1500,
   parameter int H1       = 750,
   parameter int LEAD_CYC = 768,
   parameter int GAP      = 60000
) (
   input  logic       reset,
   input  logic       clock,
   input  logic       ce,
   input  logic       play,
   input  logic       stop,
   input  logic       motor,
   input  logic       wr,
   input  logic [7:0] din,
   input  logic       last,
   output logic       full,
   output logic       busy,
   output logic       ear
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [15:0] H0_END   = 16'(H0 - 1);
   localparam logic [15:0] LEAD_END = 16'(LEAD_CYC - 1);
   localparam logic [15:0] GAP_END  = 16'(GAP - 1);

   typedef enum logic [2:0] {S_IDLE, S_LEADER, S_DATA, S_HOLD, S_TAIL} state_t;

   logic [8:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wp, rp;
   logic [FIFO_AW:0]   count;
   logic               empty, push, pop;
   logic [8:0]         q;

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n, cyc, cyc_n, hb;
   logic [2:0]  bitn, bitn_n;
   logic [7:0]  sh, sh_n;
   logic        eof, eof_n, ear_n, tick, bnd;

   assign empty = (count == '0);
   assign full  = (count == (FIFO_AW+1)'(DEPTH));
   assign push  = wr && !full && !stop;
   assign q     = mem[rp];
   assign busy  = (state != S_IDLE);
   assign tick  = ce && motor;
   assign hb    = sh[bitn] ? 16'(H1) : 16'(H0);

   always_ff @(posedge clock)
      if (push) mem[wp] <= {last, din};

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (stop) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         cyc   <= '0;
         bitn  <= '0;
         sh    <= '0;
         eof   <= 1'b0;
         ear   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         cyc   <= cyc_n;
         bitn  <= bitn_n;
         sh    <= sh_n;
         eof   <= eof_n;
         ear   <= ear_n;
      end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cyc_n   = cyc;
      bitn_n  = bitn;
      sh_n    = sh;
      eof_n   = eof;
      ear_n   = ear;
      pop     = 1'b0;
      bnd     = 1'b0;
      case (state)
         S_IDLE:
            if (play) begin
               state_n = S_LEADER;
               cnt_n   = '0;
               cyc_n   = '0;
               ear_n   = 1'b1;
            end
         S_LEADER:
            if (tick) begin
               if (cnt == H0_END) begin
                  cnt_n = '0;
                  if (ear) ear_n = 1'b0;
                  else if (cyc == LEAD_END) bnd = 1'b1;
                  else begin
                     ear_n = 1'b1;
                     cyc_n = cyc + 16'd1;
                  end
               end else cnt_n = cnt + 16'd1;
            end
         S_DATA:
            if (tick) begin
               if (cnt == hb - 16'd1) begin
                  cnt_n = '0;
                  if (ear) ear_n = 1'b0;
                  else if (bitn == 3'd0) bnd = 1'b1;
                  else begin
                     ear_n  = 1'b1;
                     bitn_n = bitn - 3'd1;
                  end
               end else cnt_n = cnt + 16'd1;
            end
         // Underrun: sit low without counting until the host supplies the next byte.
         S_HOLD:
            if (motor && !empty) bnd = 1'b1;
         S_TAIL:
            if (tick) begin
               if (cnt == GAP_END) begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
                  eof_n   = 1'b0;
               end else cnt_n = cnt + 16'd1;
            end
         default: state_n = S_IDLE;
      endcase
      // Byte boundary is resolved on the same tick that ends the previous bit, so no tick is lost.
      if (bnd) begin
         if (!empty) begin
            pop     = 1'b1;
            sh_n    = q[7:0];
            eof_n   = q[8];
            bitn_n  = 3'd7;
            cnt_n   = '0;
            ear_n   = 1'b1;
            state_n = S_DATA;
         end else if (eof) begin
            state_n = S_TAIL;
            cnt_n   = '0;
            ear_n   = 1'b0;
         end else begin
            state_n = S_HOLD;
            ear_n   = 1'b0;
         end
      end
      if (stop) begin
         state_n = S_IDLE;
         cnt_n   = '0;
         cyc_n   = '0;
         eof_n   = 1'b0;
         ear_n   = 1'b0;
         pop     = 1'b0;
      end
   end

endmodule
